// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/UDIV/SDIV sequencer for the E stage; one result bit per cycle, WIDTH+1 cycle latency (1 for divide-by-zero).
// Holds F/D/E via StallMD while accepting or running; the result is presented for one DONE cycle and cannot be back-pressured.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic [1:0]       OpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic [3:0]       WA3E,
  input  logic             FlushE,
  output logic             StallMD,
  output logic             Busy,
  output logic             RegWriteMD,
  output logic [WIDTH-1:0] ResultM,
  output logic [3:0]       WA3M
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // mcand: multiplicand, or divisor for divides.
  // mplier: multiplier, or dividend shifting out / quotient shifting in.
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] rem;
  logic [CNTW-1:0]  cnt;
  logic             is_div_q;
  logic             neg_q;
  logic [3:0]       wa3_pend;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       wa3_q;

  logic             op_div_e;
  logic             op_sdiv_e;
  logic             div_zero_e;
  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             div_ge;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] quo_final;
  logic [WIDTH-1:0] acc_step;

  assign op_div_e   = (OpE == 2'b01) || (OpE == 2'b10);
  assign op_sdiv_e  = (OpE == 2'b10);
  assign div_zero_e = op_div_e && (SrcBE == '0);
  assign accept     = (state == IDLE) && StartE && !FlushE;
  assign last_iter  = (cnt == '0);

  // abs(MIN) wraps back to MIN, which read as unsigned is exactly 2^(WIDTH-1).
  assign a_abs = (op_sdiv_e && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
  assign b_abs = (op_sdiv_e && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;

  // Restoring step: the stored remainder is always below the divisor, so only
  // the shifted trial value needs the extra bit.
  assign rem_shift = {rem, mplier[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, mcand};
  assign div_ge    = (rem_shift >= {1'b0, mcand});
  assign rem_step  = div_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_step  = {mplier[WIDTH-2:0], div_ge};
  assign quo_final = neg_q ? -quo_step : quo_step;

  assign acc_step = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = div_zero_e ? DONE : RUN;
        end
      end
      RUN: begin
        if (FlushE) begin
          state_nxt = IDLE;
        end else if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem      <= '0;
      cnt      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      wa3_pend <= '0;
      result_q <= '0;
      wa3_q    <= '0;
    end else if (accept) begin
      acc      <= '0;
      rem      <= '0;
      cnt      <= CNTW'(WIDTH - 1);
      is_div_q <= op_div_e;
      neg_q    <= op_sdiv_e && (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
      wa3_pend <= WA3E;
      mcand    <= op_div_e ? b_abs : SrcAE;
      mplier   <= op_div_e ? a_abs : SrcBE;
      if (div_zero_e) begin
        result_q <= '0;
        wa3_q    <= WA3E;
      end
    end else if ((state == RUN) && !FlushE) begin
      cnt <= cnt - CNTW'(1);
      if (is_div_q) begin
        rem    <= rem_step;
        mplier <= quo_step;
      end else begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
      // Result and destination only change on entry to DONE so they hold otherwise.
      if (last_iter) begin
        result_q <= is_div_q ? quo_final : acc_step;
        wa3_q    <= wa3_pend;
      end
    end
  end

  assign Busy       = (state != IDLE);
  assign RegWriteMD = (state == DONE);
  assign StallMD    = accept || (state == RUN);
  assign ResultM    = result_q;
  assign WA3M       = wa3_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed table, random ops against an arithmetic model, flush/reset/back-to-back sequences.
module tb_muldiv_sequencer;

  logic        clk;
  logic        reset;
  logic        StartE;
  logic [1:0]  OpE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic [3:0]  WA3E;
  logic        FlushE;
  logic        StallMD;
  logic        Busy;
  logic        RegWriteMD;
  logic [31:0] ResultM;
  logic [3:0]  WA3M;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int pulse_cyc;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .StartE     (StartE),
    .OpE        (OpE),
    .SrcAE      (SrcAE),
    .SrcBE      (SrcBE),
    .WA3E       (WA3E),
    .FlushE     (FlushE),
    .StallMD    (StallMD),
    .Busy       (Busy),
    .RegWriteMD (RegWriteMD),
    .ResultM    (ResultM),
    .WA3M       (WA3M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  wa;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the architectural definition of each op.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    if (op == 2'b01) return (b == 0) ? 32'd0 : a / b;
    if (op == 2'b10) begin
      if (b == 0) return 32'd0;
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      return q[31:0];
    end
    return a * b;
  endfunction

  // Issue one op; inputs driven mid-cycle, outputs sampled 1 time unit later.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] wa, input logic [31:0] exp, input bit hold);
    bit dz;
    int stalls;
    int lat;
    dz = ((op == 2'b01) || (op == 2'b10)) && (b == 0);
    StartE = 1'b1; FlushE = 1'b0; OpE = op; SrcAE = a; SrcBE = b; WA3E = wa;
    #1;
    stalls = 0;
    lat = -1;
    for (int c = 0; c < 100; c++) begin
      if (StallMD) stalls++;
      if (RegWriteMD) begin
        lat = c;
        pulse_cyc = cyc;
        chk("result", ResultM, exp);
        chk("wa3m", {28'd0, WA3M}, {28'd0, wa});
        break;
      end
      @(negedge clk);
      if (!hold) StartE = 1'b0;
      #1;
    end
    chk("latency", lat, dz ? 32'd1 : 32'd33);
    chk("stall_cycles", stalls, dz ? 32'd1 : 32'd33);
    @(negedge clk);
    if (!hold) StartE = 1'b0;
    #1;
    chk("single_pulse", {31'd0, RegWriteMD}, 32'd0);
    chk("idle_after_done", {31'd0, Busy}, 32'd0);
    chk("result_held", ResultM, exp);
  endtask

  vec_t tbl[12];

  initial begin
    int p1;
    int seen;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    tbl[0]  = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0003, 4'd5,  32'hFFFF_FFFD};
    tbl[1]  = '{2'b01, 32'd100,       32'd7,         4'd1,  32'd14};
    tbl[2]  = '{2'b10, 32'hFFFF_FF9C, 32'd7,         4'd2,  32'hFFFF_FFF2};
    tbl[3]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 4'd3,  32'h8000_0000};
    tbl[4]  = '{2'b01, 32'd123,       32'd0,         4'd4,  32'd0};
    tbl[5]  = '{2'b10, 32'd0,         32'd0,         4'd6,  32'd0};
    tbl[6]  = '{2'b11, 32'd5,         32'd9,         4'd7,  32'd45};
    tbl[7]  = '{2'b10, 32'd100,       32'hFFFF_FFF9, 4'd8,  32'hFFFF_FFF2};
    tbl[8]  = '{2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 4'd9,  32'd14};
    tbl[9]  = '{2'b01, 32'hFFFF_FFFF, 32'd1,         4'd10, 32'hFFFF_FFFF};
    tbl[10] = '{2'b10, 32'd7,         32'hFFFF_FF9C, 4'd11, 32'd0};
    tbl[11] = '{2'b00, 32'hFFFF_FFFD, 32'd5,         4'd15, 32'hFFFF_FFF1};

    // Reset held with a pending start request.
    reset = 1'b0; StartE = 1'b1; FlushE = 1'b0; OpE = 2'b00;
    SrcAE = 32'd3; SrcBE = 32'd4; WA3E = 4'd12;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    chk("reset_regwrite", {31'd0, RegWriteMD}, 32'd0);
    chk("reset_result", ResultM, 32'd0);
    chk("reset_wa3m", {28'd0, WA3M}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(2'b00, 32'd3, 32'd4, 4'd12, 32'd12, 1'b0);

    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].wa, tbl[i].exp, 1'b0);
    end

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 31);
      run_op(rop, ra, rb, 4'($urandom_range(0, 15)), model(rop, ra, rb), 1'b0);
    end

    // Flush during RUN cycle 10 of a multiply.
    StartE = 1'b1; OpE = 2'b00; SrcAE = 32'h1234_5678; SrcBE = 32'h0000_0FFF; WA3E = 4'd9;
    @(negedge clk);
    StartE = 1'b0;
    repeat (9) @(negedge clk);
    FlushE = 1'b1;
    #1;
    chk("flush_run_stall", {31'd0, StallMD}, 32'd1);
    @(negedge clk);
    FlushE = 1'b0;
    #1;
    chk("flush_idle", {31'd0, Busy}, 32'd0);
    chk("flush_stall_low", {31'd0, StallMD}, 32'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (RegWriteMD) seen++;
      @(negedge clk);
      #1;
    end
    chk("flush_no_write", seen, 32'd0);
    run_op(2'b00, 32'd6, 32'd7, 4'd3, 32'd42, 1'b0);

    // StartE held through DONE must not relaunch the op.
    run_op(2'b01, 32'd1000, 32'd10, 4'd2, 32'd100, 1'b1);
    StartE = 1'b0;
    @(negedge clk);
    #1;
    chk("held_start_no_relaunch", {31'd0, Busy}, 32'd0);

    // Back-to-back multiplies: second is launched in the IDLE cycle after DONE.
    run_op(2'b00, 32'd11, 32'd13, 4'd4, 32'd143, 1'b1);
    p1 = pulse_cyc;
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 32'd1, 1'b0);
    chk("b2b_pulse_gap", pulse_cyc - p1, 32'd34);

    // Asynchronous reset in the middle of RUN.
    StartE = 1'b1; OpE = 2'b10; SrcAE = 32'hFFFF_0000; SrcBE = 32'd3; WA3E = 4'd14;
    @(negedge clk);
    StartE = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, Busy}, 32'd0);
    chk("arst_stall", {31'd0, StallMD}, 32'd0);
    chk("arst_regwrite", {31'd0, RegWriteMD}, 32'd0);
    chk("arst_result", ResultM, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 4'd1, 32'hFFFF_FFFD, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
